// File: rtl/xadac_issue_pkg.sv
// -----------------------------------------------------------------------------
// xadac_issue_pkg
//   Shared types and helpers for the xadac issue slice:
//     - XLEN / IdWidth / VLEN / NoVRegsDef widths and their typedefs
//     - VRegIdxT      : vector register index
//     - issue_state_e : issue FSM encoding {IDLE, HAZ, SEND, DEC}
//     - pend_entry_t  : per-id record of an outstanding vd write
//     - vs1_idx / vs2_idx / vd_idx : instruction field extractors
//   Optional feature macro used by the slice: XADAC_ISSUE_BYPASS_EN
// -----------------------------------------------------------------------------
package xadac_issue_pkg;

  localparam int XLEN       = 32;
  localparam int IdWidth    = 3;
  localparam int VLEN       = 64;
  localparam int NoVRegsDef = 32;

  typedef logic [XLEN-1:0]                 XlenT;
  typedef logic [IdWidth-1:0]              IdT;
  typedef logic [VLEN-1:0]                 VectorT;
  typedef logic [$clog2(NoVRegsDef)-1:0]   VRegIdxT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HAZ  = 2'd1,
    SEND = 2'd2,
    DEC  = 2'd3
  } issue_state_e;

  typedef struct packed {
    logic    valid;
    VRegIdxT vd;
  } pend_entry_t;

  // vs3 shares the vd field, so there is no separate vs3 extractor.
  function automatic VRegIdxT vs1_idx(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic VRegIdxT vs2_idx(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  function automatic VRegIdxT vd_idx(input logic [31:0] instr);
    return instr[11:7];
  endfunction

endpackage

// File: rtl/xadac_issue_if.sv
// -----------------------------------------------------------------------------
// xadac_issue_if
//   Request/response channel between the issue stage (mst) and the EX stage
//   (slv).
//   Request  : req_valid/req_ready handshake carrying id, instruction, scalar
//              and vector operands; EX answers with accept and clobber flags
//              in the same cycle as req_ready.
//   Response : resp_valid/resp_ready handshake carrying id, vector result
//              (resp_vd, resp_vd_write) and scalar result (resp_rd,
//              resp_rd_write).
// -----------------------------------------------------------------------------
interface xadac_issue_if
  import xadac_issue_pkg::*;
  ();

  // request channel
  logic   req_valid;
  logic   req_ready;
  IdT     req_id;
  logic [31:0] req_instr;
  XlenT   req_rs1;
  XlenT   req_rs2;
  VectorT req_vs1;
  VectorT req_vs2;
  VectorT req_vs3;
  logic   req_accept;
  logic   req_rd_clobber;
  logic   req_vd_clobber;

  // response channel
  logic   resp_valid;
  logic   resp_ready;
  IdT     resp_id;
  VectorT resp_vd;
  logic   resp_vd_write;
  XlenT   resp_rd;
  logic   resp_rd_write;

  modport mst (
    output req_valid, req_id, req_instr, req_rs1, req_rs2,
           req_vs1, req_vs2, req_vs3, resp_ready,
    input  req_ready, req_accept, req_rd_clobber, req_vd_clobber,
           resp_valid, resp_id, resp_vd, resp_vd_write, resp_rd, resp_rd_write
  );

  modport slv (
    input  req_valid, req_id, req_instr, req_rs1, req_rs2,
           req_vs1, req_vs2, req_vs3, resp_ready,
    output req_ready, req_accept, req_rd_clobber, req_vd_clobber,
           resp_valid, resp_id, resp_vd, resp_vd_write, resp_rd, resp_rd_write
  );

endinterface

// File: rtl/xadac_issue_vrf.sv
// -----------------------------------------------------------------------------
// xadac_issue_vrf
//   Vector register file: NoVRegs x VectorT, three combinational read ports,
//   one synchronous write port.
//   Macro XADAC_ISSUE_BYPASS_EN: a read whose index matches the same-cycle
//   write returns the write data instead of the stored value.
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   i_ra_idx/i_rb_idx/i_rc_idx read indices
//   o_ra_data/o_rb_data/o_rc_data read data
//   i_we, i_wa, i_wd          write enable, index, data
// Parameters
//   NoVRegs   number of registers
//   ResetVrf  1: contents cleared by rstn; 0: contents untouched by reset
// -----------------------------------------------------------------------------
module xadac_issue_vrf
  import xadac_issue_pkg::*;
#(
  parameter int NoVRegs  = NoVRegsDef,
  parameter int ResetVrf = 1
) (
  input  logic    clk,
  input  logic    rstn,
  input  VRegIdxT i_ra_idx,
  input  VRegIdxT i_rb_idx,
  input  VRegIdxT i_rc_idx,
  output VectorT  o_ra_data,
  output VectorT  o_rb_data,
  output VectorT  o_rc_data,
  input  logic    i_we,
  input  VRegIdxT i_wa,
  input  VectorT  i_wd
);

  VectorT r_mem [NoVRegs];

  function automatic VectorT read_port(input VRegIdxT idx);
    VectorT data;
    data = r_mem[idx];
`ifdef XADAC_ISSUE_BYPASS_EN
    if (i_we && (i_wa == idx)) data = i_wd;
`else
    // Stored value only; a same-cycle write becomes visible next cycle.
`endif
    return data;
  endfunction

  assign o_ra_data = read_port(i_ra_idx);
  assign o_rb_data = read_port(i_rb_idx);
  assign o_rc_data = read_port(i_rc_idx);

  // NOTE: a memory only gets a reset when its contents must be architecturally
  // defined; clearing every entry costs a reset net on each flop, so it is a
  // build-time choice here rather than always on.
  if (ResetVrf != 0) begin : g_rst
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < NoVRegs; i++) r_mem[i] <= '0;
      end else if (i_we) begin
        r_mem[i_wa] <= i_wd;
      end
    end
  end else begin : g_norst
    always_ff @(posedge clk) begin
      if (i_we) r_mem[i_wa] <= i_wd;
    end
  end

endmodule

// File: rtl/xadac_issue.sv
// -----------------------------------------------------------------------------
// xadac_issue
//   Initiator side of the xadac EX channel. Buffers one core request, reads
//   vs1/vs2/vs3 from the internal VRF, stalls on vector RAW/WAW hazards and
//   on reuse of an id with an outstanding vd write, issues to EX and reports
//   the decision to the core. EX responses write vd back into the VRF and
//   return scalar rd results to the core through a one-entry result register.
// Ports
//   clk, rstn                   clock, asynchronous active-low reset
//   i_core_req_*/o_core_req_ready  core offload request (one-entry buffer)
//   o_core_dec_*                one-cycle decision pulse (id, accept, rd clobber)
//   o_core_res_*/i_core_res_ready  scalar result towards the core
//   ex                          xadac_issue_if.mst channel to EX
// Parameters
//   NoVRegs   number of vector registers
//   ResetVrf  1: VRF cleared at reset; 0: VRF not reset
// Macro XADAC_ISSUE_BYPASS_EN
//   Defined: the hazard check ignores pend/table entries being retired by the
//   same-cycle response and VRF reads forward the same-cycle write, so a
//   dependent instruction reaches SEND the cycle after its producer's response.
//   Undefined: the hazard clears one cycle after the registered update.
// -----------------------------------------------------------------------------
module xadac_issue
  import xadac_issue_pkg::*;
#(
  parameter int NoVRegs  = NoVRegsDef,
  parameter int ResetVrf = 1
) (
  input  logic        clk,
  input  logic        rstn,
  // core request
  input  logic        i_core_req_valid,
  output logic        o_core_req_ready,
  input  IdT          i_core_req_id,
  input  logic [31:0] i_core_req_instr,
  input  XlenT        i_core_req_rs1,
  input  XlenT        i_core_req_rs2,
  // core decision
  output logic        o_core_dec_valid,
  output IdT          o_core_dec_id,
  output logic        o_core_dec_accept,
  output logic        o_core_dec_rd_clob,
  // core result
  output logic        o_core_res_valid,
  input  logic        i_core_res_ready,
  output IdT          o_core_res_id,
  output XlenT        o_core_res_rd,
  // EX channel
  xadac_issue_if.mst  ex
);

`ifdef XADAC_ISSUE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  issue_state_e r_state;
  issue_state_e w_next_state;
  logic         r_alive;           // low during reset, high from first edge after

  IdT           r_id;
  logic [31:0]  r_instr;
  XlenT         r_rs1;
  XlenT         r_rs2;
  logic         r_accept;
  logic         r_rd_clob;

  logic [NoVRegs-1:0] r_pend;      // vreg has an outstanding write
  pend_entry_t  r_tbl [2**IdWidth];

  logic         r_res_valid;
  IdT           r_res_id;
  XlenT         r_res_rd;

  // ---------------------------------------------------------------------------
  // Decode and handshakes
  // ---------------------------------------------------------------------------
  VRegIdxT w_vs1_idx;
  VRegIdxT w_vs2_idx;
  VRegIdxT w_vd_idx;
  logic    w_core_req_ready;
  logic    w_core_hs;
  logic    w_req_valid;
  logic    w_req_hs;
  logic    w_resp_ready;
  logic    w_resp_hs;
  logic    w_tbl_hit;
  logic    w_clr;
  VRegIdxT w_clr_vd;
  logic    w_set;
  logic    w_hazard;

  assign w_vs1_idx = vs1_idx(r_instr);
  assign w_vs2_idx = vs2_idx(r_instr);
  assign w_vd_idx  = vd_idx(r_instr);

  assign w_core_req_ready = r_alive && (r_state == IDLE);
  assign w_core_hs        = i_core_req_valid && w_core_req_ready;
  assign w_req_hs         = w_req_valid && ex.req_ready;

  // One-entry result register that can be refilled in the cycle it drains.
  assign w_resp_ready = !r_res_valid || i_core_res_ready;
  assign w_resp_hs    = ex.resp_valid && w_resp_ready;

  assign w_tbl_hit = r_tbl[ex.resp_id].valid;
  assign w_clr     = w_resp_hs && w_tbl_hit;
  assign w_clr_vd  = r_tbl[ex.resp_id].vd;
  assign w_set     = w_req_hs && ex.req_accept && ex.req_vd_clobber;

  // Pending bit as seen by the hazard check; with bypass, an entry retiring
  // this cycle no longer blocks.
  function automatic logic pend_eff(input VRegIdxT idx);
    return r_pend[idx] && !(Bypass && w_clr && (w_clr_vd == idx));
  endfunction

  // Raw fields are checked regardless of whether the instruction reads them;
  // vs3 and vd share [11:7] so one term covers both RAW on vs3 and WAW on vd.
  assign w_hazard = pend_eff(w_vs1_idx) || pend_eff(w_vs2_idx) || pend_eff(w_vd_idx)
                 || (r_tbl[r_id].valid && !(Bypass && w_clr && (ex.resp_id == r_id)));

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_alive <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_req_valid  = 1'b0;
    unique case (r_state)
      IDLE: if (w_core_hs) w_next_state = HAZ;
      HAZ:  if (!w_hazard) w_next_state = SEND;
      SEND: begin
        w_req_valid = 1'b1;
        if (ex.req_ready) w_next_state = DEC;
      end
      DEC:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request buffer and decision capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_id      <= '0;
      r_instr   <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_accept  <= 1'b0;
      r_rd_clob <= 1'b0;
    end else begin
      if (w_core_hs) begin
        r_id    <= i_core_req_id;
        r_instr <= i_core_req_instr;
        r_rs1   <= i_core_req_rs1;
        r_rs2   <= i_core_req_rs2;
      end
      if (w_req_hs) begin
        r_accept  <= ex.req_accept;
        r_rd_clob <= ex.req_rd_clobber;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending vreg bits and id table. A retire and a new record in the same
  // cycle always target different vregs/ids (the hazard check guarantees it),
  // so both updates are applied.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend <= '0;
      for (int i = 0; i < 2**IdWidth; i++) r_tbl[i] <= '0;
    end else begin
      if (w_clr) begin
        r_pend[w_clr_vd]   <= 1'b0;
        r_tbl[ex.resp_id]  <= '0;
      end
      if (w_set) begin
        r_pend[w_vd_idx] <= 1'b1;
        r_tbl[r_id]      <= '{valid: 1'b1, vd: w_vd_idx};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scalar result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_rd    <= '0;
    end else begin
      if (r_res_valid && i_core_res_ready) r_res_valid <= 1'b0;
      if (w_resp_hs && ex.resp_rd_write) begin
        r_res_valid <= 1'b1;
        r_res_id    <= ex.resp_id;
        r_res_rd    <= ex.resp_rd;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Vector register file
  // ---------------------------------------------------------------------------
  VectorT w_vs1_data;
  VectorT w_vs2_data;
  VectorT w_vs3_data;

  xadac_issue_vrf #(
    .NoVRegs  (NoVRegs),
    .ResetVrf (ResetVrf)
  ) u_vrf (
    .clk       (clk),
    .rstn      (rstn),
    .i_ra_idx  (w_vs1_idx),
    .i_rb_idx  (w_vs2_idx),
    .i_rc_idx  (w_vd_idx),
    .o_ra_data (w_vs1_data),
    .o_rb_data (w_vs2_data),
    .o_rc_data (w_vs3_data),
    .i_we      (w_clr && ex.resp_vd_write),
    .i_wa      (w_clr_vd),
    .i_wd      (ex.resp_vd)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_core_req_ready   = w_core_req_ready;
  assign o_core_dec_valid   = (r_state == DEC);
  assign o_core_dec_id      = r_id;
  assign o_core_dec_accept  = (r_state == DEC) && r_accept;
  assign o_core_dec_rd_clob = (r_state == DEC) && r_rd_clob;
  assign o_core_res_valid   = r_res_valid;
  assign o_core_res_id      = r_res_id;
  assign o_core_res_rd      = r_res_rd;

  assign ex.req_valid  = w_req_valid;
  assign ex.req_id     = r_id;
  assign ex.req_instr  = r_instr;
  assign ex.req_rs1    = r_rs1;
  assign ex.req_rs2    = r_rs2;
  assign ex.req_vs1    = w_vs1_data;
  assign ex.req_vs2    = w_vs2_data;
  assign ex.req_vs3    = w_vs3_data;
  assign ex.resp_ready = w_resp_ready;

  // A vd write for an id with no recorded entry has nowhere to go; the data
  // is dropped, and this flags the protocol error in simulation.
  a_orphan_vd_write: assert property (@(posedge clk) disable iff (!rstn)
    !(w_resp_hs && ex.resp_vd_write && !w_tbl_hit));

endmodule

// File: tb/tb_xadac_issue.sv
// -----------------------------------------------------------------------------
// tb_xadac_issue
//   Directed bench for xadac_issue. The bench plays both the core and the EX
//   stage; expected values are hand-computed per scenario. Inputs are driven
//   and outputs sampled 1 time unit after the rising edge.
//   Timing checks follow XADAC_ISSUE_BYPASS_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_xadac_issue;
  import xadac_issue_pkg::*;

`ifdef XADAC_ISSUE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        core_req_valid;
  logic        core_req_ready;
  IdT          core_req_id;
  logic [31:0] core_req_instr;
  XlenT        core_req_rs1;
  XlenT        core_req_rs2;
  logic        core_dec_valid;
  IdT          core_dec_id;
  logic        core_dec_accept;
  logic        core_dec_rd_clob;
  logic        core_res_valid;
  logic        core_res_ready;
  IdT          core_res_id;
  XlenT        core_res_rd;

  xadac_issue_if ex_if ();

  xadac_issue dut (
    .clk                (clk),
    .rstn               (rstn),
    .i_core_req_valid   (core_req_valid),
    .o_core_req_ready   (core_req_ready),
    .i_core_req_id      (core_req_id),
    .i_core_req_instr   (core_req_instr),
    .i_core_req_rs1     (core_req_rs1),
    .i_core_req_rs2     (core_req_rs2),
    .o_core_dec_valid   (core_dec_valid),
    .o_core_dec_id      (core_dec_id),
    .o_core_dec_accept  (core_dec_accept),
    .o_core_dec_rd_clob (core_dec_rd_clob),
    .o_core_res_valid   (core_res_valid),
    .i_core_res_ready   (core_res_ready),
    .o_core_res_id      (core_res_id),
    .o_core_res_rd      (core_res_rd),
    .ex                 (ex_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Core offers one instruction; returns in the cycle after the handshake.
  task automatic core_issue(input IdT id, input logic [31:0] instr);
    int n = 0;
    while (!core_req_ready && n < 8) begin
      step();
      n++;
    end
    check("core_ready_wait", core_req_ready, 1'b1);
    core_req_valid = 1'b1;
    core_req_id    = id;
    core_req_instr = instr;
    core_req_rs1   = 32'h100 + 32'(id);
    core_req_rs2   = 32'h200 + 32'(id);
    step();
    core_req_valid = 1'b0;
  endtask

  // EX takes the pending request; returns in the cycle after the handshake.
  task automatic ex_take(input logic acc, input logic rdc, input logic vdc);
    int n = 0;
    while (!ex_if.req_valid && n < 8) begin
      step();
      n++;
    end
    check("req_valid_wait", ex_if.req_valid, 1'b1);
    ex_if.req_ready      = 1'b1;
    ex_if.req_accept     = acc;
    ex_if.req_rd_clobber = rdc;
    ex_if.req_vd_clobber = vdc;
    step();
    ex_if.req_ready      = 1'b0;
    ex_if.req_accept     = 1'b0;
    ex_if.req_rd_clobber = 1'b0;
    ex_if.req_vd_clobber = 1'b0;
  endtask

  // One response beat, assuming resp_ready is high.
  task automatic ex_resp(input IdT id, input logic vdw, input VectorT vd);
    ex_if.resp_valid    = 1'b1;
    ex_if.resp_id       = id;
    ex_if.resp_vd_write = vdw;
    ex_if.resp_vd       = vd;
    ex_if.resp_rd_write = 1'b0;
    step();
    ex_if.resp_valid    = 1'b0;
    ex_if.resp_vd_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    core_req_valid       = 1'b0;
    core_req_id          = '0;
    core_req_instr       = '0;
    core_req_rs1         = '0;
    core_req_rs2         = '0;
    core_res_ready       = 1'b1;
    ex_if.req_ready      = 1'b0;
    ex_if.req_accept     = 1'b0;
    ex_if.req_rd_clobber = 1'b0;
    ex_if.req_vd_clobber = 1'b0;
    ex_if.resp_valid     = 1'b0;
    ex_if.resp_id        = '0;
    ex_if.resp_vd        = '0;
    ex_if.resp_vd_write  = 1'b0;
    ex_if.resp_rd        = '0;
    ex_if.resp_rd_write  = 1'b0;

    // ---- reset ----
    step();
    check("rst_req_ready", core_req_ready, 1'b0);
    check("rst_req_valid", ex_if.req_valid, 1'b0);
    check("rst_dec_valid", core_dec_valid, 1'b0);
    check("rst_res_valid", core_res_valid, 1'b0);
    rstn = 1'b1;
    step();
    check("post_rst_ready", core_req_ready, 1'b1);

    // ---- 1: basic issue, vd=4 (instr 0x0000_0277: vd=4, vs1=0, vs2=0) ----
    core_req_valid = 1'b1;
    core_req_id    = 3'd1;
    core_req_instr = 32'h0000_0277;
    core_req_rs1   = 32'h1111;
    core_req_rs2   = 32'h2222;
    step();
    core_req_valid = 1'b0;
    check("t1_haz_cycle", ex_if.req_valid, 1'b0);
    step();
    check("t1_send_lat2", ex_if.req_valid, 1'b1);
    check("t1_req_id", ex_if.req_id, 3'd1);
    check("t1_req_rs1", ex_if.req_rs1, 32'h1111);
    check("t1_req_instr", ex_if.req_instr, 32'h0000_0277);
    ex_take(1'b1, 1'b0, 1'b1);
    check("t1_dec_valid", core_dec_valid, 1'b1);
    check("t1_dec_id", core_dec_id, 3'd1);
    check("t1_dec_accept", core_dec_accept, 1'b1);
    check("t1_dec_rd_clob", core_dec_rd_clob, 1'b0);
    check("t1_ready_in_dec", core_req_ready, 1'b0);
    check("t1_pend4_set", dut.r_pend[4], 1'b1);
    step();
    check("t1_dec_one_cycle", core_dec_valid, 1'b0);
    check("t1_ready_b2b", core_req_ready, 1'b1);
    ex_resp(3'd1, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5);
    check("t1_vrf4", dut.u_vrf.r_mem[4], 64'hA5A5_A5A5_A5A5_A5A5);
    check("t1_pend4_clr", dut.r_pend[4], 1'b0);
    check("t1_tbl1_clr", dut.r_tbl[1].valid, 1'b0);

    // ---- 2: RAW on vs1=4 (instr 0x0002_02D7: vs1=4, vd=5) ----
    core_issue(3'd3, 32'h0000_0277);
    ex_take(1'b1, 1'b0, 1'b1);
    step();
    core_issue(3'd4, 32'h0002_02D7);
    for (int i = 0; i < 3; i++) begin
      check("t2_stall", ex_if.req_valid, 1'b0);
      step();
    end
    ex_if.resp_valid    = 1'b1;
    ex_if.resp_id       = 3'd3;
    ex_if.resp_vd_write = 1'b1;
    ex_if.resp_vd       = 64'h1122_3344_5566_7788;
    #1;
    check("t2_hold_at_resp", ex_if.req_valid, 1'b0);
    step();
    ex_if.resp_valid    = 1'b0;
    ex_if.resp_vd_write = 1'b0;
    check("t2_send_after_resp", ex_if.req_valid, Byp);
    if (!Byp) step();
    check("t2_send", ex_if.req_valid, 1'b1);
    check("t2_vs1_new", ex_if.req_vs1, 64'h1122_3344_5566_7788);
    check("t2_req_id", ex_if.req_id, 3'd4);
    ex_take(1'b1, 1'b0, 1'b0);
    check("t2_dec_accept", core_dec_accept, 1'b1);
    check("t2_pend4_clr", dut.r_pend[4], 1'b0);
    check("t2_pend5_norec", dut.r_pend[5], 1'b0);
    step();

    // ---- 3: unmatched instruction ----
    core_issue(3'd5, 32'hFFFF_FFFF);
    ex_take(1'b0, 1'b0, 1'b1);
    check("t3_dec_valid", core_dec_valid, 1'b1);
    check("t3_dec_accept", core_dec_accept, 1'b0);
    check("t3_dec_id", core_dec_id, 3'd5);
    check("t3_pend31", dut.r_pend[31], 1'b0);
    check("t3_tbl5", dut.r_tbl[5].valid, 1'b0);
    step();
    check("t3_idle_ready", core_req_ready, 1'b1);

    // ---- 4: scalar results with core back-pressure ----
    core_res_ready      = 1'b0;
    ex_if.resp_valid    = 1'b1;
    ex_if.resp_id       = 3'd6;
    ex_if.resp_rd_write = 1'b1;
    ex_if.resp_rd       = 32'h1234;
    #1;
    check("t4_resp_ready_empty", ex_if.resp_ready, 1'b1);
    step();
    ex_if.resp_id = 3'd7;
    ex_if.resp_rd = 32'h5678;
    #1;
    check("t4_resp_stall", ex_if.resp_ready, 1'b0);
    check("t4_res_valid", core_res_valid, 1'b1);
    check("t4_res_id", core_res_id, 3'd6);
    check("t4_res_rd", core_res_rd, 32'h1234);
    step();
    check("t4_res_held", core_res_rd, 32'h1234);
    check("t4_resp_still_stall", ex_if.resp_ready, 1'b0);
    core_res_ready = 1'b1;
    #1;
    check("t4_passthru_ready", ex_if.resp_ready, 1'b1);
    step();
    ex_if.resp_valid    = 1'b0;
    ex_if.resp_rd_write = 1'b0;
    check("t4_second_valid", core_res_valid, 1'b1);
    check("t4_second_id", core_res_id, 3'd7);
    check("t4_second_rd", core_res_rd, 32'h5678);
    step();
    check("t4_drained", core_res_valid, 1'b0);

    // ---- 5: id reuse stall (vd=6 then vd=8/vs1=9/vs2=10 on id 2) ----
    core_issue(3'd2, 32'h0000_0357);
    ex_take(1'b1, 1'b0, 1'b1);
    step();
    check("t5_tbl2_set", dut.r_tbl[2].valid, 1'b1);
    core_issue(3'd2, 32'h00A4_8457);
    for (int i = 0; i < 3; i++) begin
      check("t5_stall", ex_if.req_valid, 1'b0);
      step();
    end
    ex_resp(3'd2, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
    check("t5_pend6_clr", dut.r_pend[6], 1'b0);
    check("t5_vrf6_unwritten", dut.u_vrf.r_mem[6], 64'h0);
    ex_take(1'b1, 1'b1, 1'b1);
    check("t5_dec_id", core_dec_id, 3'd2);
    check("t5_dec_accept", core_dec_accept, 1'b1);
    check("t5_dec_rd_clob", core_dec_rd_clob, 1'b1);
    check("t5_pend8_set", dut.r_pend[8], 1'b1);
    step();

    // ---- 6: reset while in SEND with pend[7] set ----
    core_issue(3'd0, 32'h0000_03D7);
    ex_take(1'b1, 1'b0, 1'b1);
    step();
    check("t6_pend7_set", dut.r_pend[7], 1'b1);
    core_issue(3'd1, 32'h0000_0057);
    step();
    check("t6_in_send", ex_if.req_valid, 1'b1);
    rstn = 1'b0;
    #1;
    check("t6_rst_req_valid", ex_if.req_valid, 1'b0);
    check("t6_rst_ready", core_req_ready, 1'b0);
    check("t6_rst_pend7", dut.r_pend[7], 1'b0);
    check("t6_rst_tbl0", dut.r_tbl[0].valid, 1'b0);
    step();
    rstn = 1'b1;
    step();
    step();
    check("t6_ready_after", core_req_ready, 1'b1);
    check("t6_dec_quiet", core_dec_valid, 1'b0);
    check("t6_vrf4_cleared", dut.u_vrf.r_mem[4], 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
